// File: rtl/serial_byte_receiver.sv
// Serial-in / parallel-out frame receiver.
// Detects a start bit, assembles DATA_W data bits and checks the stop bit.
// Every state change is qualified by bit_en. Consumer handshake (rd_ack) and
// error clearing (clr_err) act on every clock edge. All outputs are registered.
module serial_byte_receiver #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              bit_en,
  input  logic              serial_in,
  input  logic              rd_ack,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // Counter must reach DATA_W without wrapping inside a frame.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   sh_r;
  logic [DATA_W-1:0]   sh_next_s;

  // Shift one serial bit into the assembly register in the configured order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh,
                                                 input logic              b);
    logic [DATA_W-1:0] res;
    res = sh;
    if (LSB_FIRST) begin
      res = {b, sh[DATA_W-1:1]};
    end else begin
      res = {sh[DATA_W-2:0], b};
    end
    return res;
  endfunction

  // Next value of the shift register if a data bit is sampled this edge.
  always_comb begin
    sh_next_s = shift_in(sh_r, serial_in);
  end

  // Frame FSM, bit counter, shift register and all registered outputs.
  // Ordering matters: the handshake/clear defaults come first so that a
  // simultaneous load or a newly detected error overrides them.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      sh_r       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Consumer took the word; a load later in this block wins.
      if (rd_ack && data_valid) begin
        data_valid <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end

      // Clear sticky flags; a new error later in this block wins.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        frame_err <= frame_err;
        overrun   <= overrun;
      end

      if (bit_en) begin
        case (state_r)
          ST_IDLE: begin
            if (!serial_in) begin
              state_r <= ST_DATA;
              cnt_r   <= '0;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end

          ST_DATA: begin
            sh_r  <= sh_next_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == LAST_BIT) begin
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_DATA;
            end
          end

          ST_STOP: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            if (serial_in) begin
              if (!data_valid || rd_ack) begin
                data_out   <= sh_r;
                data_valid <= 1'b1;
              end else begin
                // Unread word still held: drop the new one.
                overrun <= 1'b1;
              end
            end else begin
              // Bad stop bit: word discarded, held output untouched.
              frame_err <= 1'b1;
            end
          end

          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
        sh_r    <= sh_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver (DATA_W=8, LSB first).
module tb_serial_byte_receiver;

  logic       clock;
  logic       resetn;
  logic       bit_en;
  logic       serial_in;
  logic       rd_ack;
  logic       clr_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  logic       mdl_valid = 1'b0;

  serial_byte_receiver #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .rd_ack     (rd_ack),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One strobed bit followed by gap-1 unstrobed cycles with random line noise.
  task automatic send_bit(input logic b, input int gap, input logic ack,
                          input logic clr, input logic exp_busy);
    serial_in = b;
    bit_en    = 1'b1;
    rd_ack    = ack;
    clr_err   = clr;
    tick();
    bit_en  = 1'b0;
    rd_ack  = 1'b0;
    clr_err = 1'b0;
    for (int i = 1; i < gap; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
      chk("gap_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("gap_valid", {31'd0, data_valid}, {31'd0, mdl_valid});
    end
  endtask

  // Full frame: start, 8 data bits LSB first, stop bit value given.
  task automatic send_frame(input logic [7:0] w, input logic stop, input int gap,
                            input logic ack, input logic clr);
    logic load;
    send_bit(1'b0, gap, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], gap, 1'b0, 1'b0, 1'b1);
    end
    load = stop && (!mdl_valid || ack);
    if (load) begin
      sb_q.push_back(w);
      mdl_valid = 1'b1;
    end else if (ack) begin
      mdl_valid = 1'b0;
    end
    send_bit(stop, gap, ack, clr, 1'b0);
    serial_in = 1'b1;
  endtask

  task automatic ack_word();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    mdl_valid = 1'b0;
    chk("ack_clears_valid", {31'd0, data_valid}, 32'd0);
  endtask

  // Monitor: every new word presented (valid rise or data change while valid).
  logic       prev_valid = 1'b0;
  logic [7:0] prev_out   = 8'h00;
  always @(negedge clock) begin
    if (resetn === 1'b1 && data_valid === 1'b1 &&
        (prev_valid !== 1'b1 || data_out !== prev_out)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", data_out);
      end else begin
        chk("word", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
      end
    end
    prev_valid <= data_valid;
    prev_out   <= data_out;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] w99;

  initial begin
    // 1. Reset with random inputs
    resetn    = 1'b0;
    bit_en    = 1'($urandom_range(0, 1));
    serial_in = 1'($urandom_range(0, 1));
    rd_ack    = 1'($urandom_range(0, 1));
    clr_err   = 1'($urandom_range(0, 1));
    tick();
    tick();
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1; bit_en = 1'b0; serial_in = 1'b1; rd_ack = 1'b0; clr_err = 1'b0;
    tick();

    // Idle line with strobes does not start a frame
    send_bit(1'b1, 1, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2. 0xA5 back-to-back strobes
    send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b0);
    chk("a5_data", {24'd0, data_out}, 32'hA5);
    chk("a5_valid", {31'd0, data_valid}, 32'd1);
    chk("a5_ferr", {31'd0, frame_err}, 32'd0);
    chk("a5_busy", {31'd0, busy}, 32'd0);
    ack_word();

    // 3. 0x3C with strobe every 4th cycle, noisy line between
    send_frame(8'h3C, 1'b1, 4, 1'b0, 1'b0);
    chk("3c_data", {24'd0, data_out}, 32'h3C);
    ack_word();

    // 4. 0xFF with bad stop bit, then clear
    send_frame(8'hFF, 1'b0, 1, 1'b0, 1'b0);
    chk("ff_ferr", {31'd0, frame_err}, 32'd1);
    chk("ff_valid", {31'd0, data_valid}, 32'd0);
    chk("ff_data_kept", {24'd0, data_out}, 32'h3C);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ff_clr", {31'd0, frame_err}, 32'd0);
    // New error on the same edge as clr_err: set wins
    send_frame(8'h0F, 1'b0, 1, 1'b0, 1'b1);
    chk("set_wins", {31'd0, frame_err}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // 5. 0x11 then 0x22 without ack -> overrun
    send_frame(8'h11, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1, 1'b0, 1'b0);
    chk("ovr_data", {24'd0, data_out}, 32'h11);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, data_valid}, 32'd1);
    clr_err = 1'b1;
    ack_word();
    clr_err = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    // Repeat with rd_ack on the second stop edge: load wins
    send_frame(8'h11, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1, 1'b1, 1'b0);
    chk("ack_load_data", {24'd0, data_out}, 32'h22);
    chk("ack_load_valid", {31'd0, data_valid}, 32'd1);
    chk("ack_load_ovr", {31'd0, overrun}, 32'd0);
    ack_word();

    // 6. Reset after 4 data bits of 0x99, then a clean 0x5A
    w99 = 8'h99;
    send_bit(1'b0, 1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_bit(w99[i], 1, 1'b0, 1'b0, 1'b1);
    end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    mdl_valid = 1'b0;
    send_frame(8'h5A, 1'b1, 2, 1'b0, 1'b0);
    chk("5a_data", {24'd0, data_out}, 32'h5A);

    repeat (4) tick();
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
